// File: rtl/result_frame_accum.sv
// Frame accumulator for the multiply-add pipeline result stream.
// Emits sum/max/min per N_SAMPLES results on a valid/ready register.
module result_frame_accum #(
  parameter int N_SAMPLES = 8,
  parameter int ACC_W     = 40
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [31:0]      in_data,
  input  logic             clear,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic [31:0]      out_max,
  output logic [31:0]      out_min,
  output logic             overrun
);

  localparam int CW = (N_SAMPLES > 1) ? $clog2(N_SAMPLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(N_SAMPLES - 1);
  localparam logic [CW-1:0] ONE  = (N_SAMPLES > 1) ? CW'(1) : '0;

  logic [CW-1:0]    cnt_q, cnt_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [31:0]      max_q, max_d;
  logic [31:0]      min_q, min_d;
  logic             ov_q, ov_d;
  logic             vld_q, vld_d;
  logic [ACC_W-1:0] sum_q, sum_d;
  logic [31:0]      omax_q, omax_d;
  logic [31:0]      omin_q, omin_d;

  logic             first;
  logic             done;
  logic             free;
  logic [ACC_W-1:0] din_x;
  logic [ACC_W-1:0] nsum;
  logic [31:0]      nmax;
  logic [31:0]      nmin;

  // A clear-cycle sample always starts a fresh frame
  assign first = clear || (cnt_q == '0);
  assign din_x = {{(ACC_W-32){1'b0}}, in_data};
  assign nsum  = first ? din_x : acc_q + din_x;
  assign nmax  = (first || in_data > max_q) ? in_data : max_q;
  assign nmin  = (first || in_data < min_q) ? in_data : min_q;
  assign done  = in_valid && !clear && (cnt_q == LAST);
  assign free  = !vld_q || out_ready;

  always_comb begin
    cnt_d = cnt_q;
    acc_d = acc_q;
    max_d = max_q;
    min_d = min_q;
    if (clear) begin
      cnt_d = in_valid ? ONE : '0;
    end else if (in_valid) begin
      cnt_d = done ? '0 : cnt_q + CW'(1);
    end
    if (in_valid) begin
      acc_d = nsum;
      max_d = nmax;
      min_d = nmin;
    end
  end

  always_comb begin
    vld_d  = vld_q;
    sum_d  = sum_q;
    omax_d = omax_q;
    omin_d = omin_q;
    ov_d   = ov_q;
    if (done && free) begin
      vld_d  = 1'b1;
      sum_d  = nsum;
      omax_d = nmax;
      omin_d = nmin;
    end else if (out_ready) begin
      vld_d = 1'b0;
    end
    if (clear) begin
      ov_d = 1'b0;
    end else if (done && !free) begin
      ov_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      acc_q  <= '0;
      max_q  <= '0;
      min_q  <= '0;
      ov_q   <= 1'b0;
      vld_q  <= 1'b0;
      sum_q  <= '0;
      omax_q <= '0;
      omin_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      acc_q  <= acc_d;
      max_q  <= max_d;
      min_q  <= min_d;
      ov_q   <= ov_d;
      vld_q  <= vld_d;
      sum_q  <= sum_d;
      omax_q <= omax_d;
      omin_q <= omin_d;
    end
  end

  assign out_valid = vld_q;
  assign out_sum   = sum_q;
  assign out_max   = omax_q;
  assign out_min   = omin_q;
  assign overrun   = ov_q;

endmodule
